// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared types and helpers for the perceptron trainer:
//   state_e    - controller states (IDLE, ACCUM, DECIDE, UPDATE)
//   W_MAX_DEF  - largest weight for the default 4-bit weight width
//   W_MIN_DEF  - smallest weight for the default 4-bit weight width
//   w_max/w_min- weight limits for an arbitrary width
//   sat_add    - signed add clamped to the representable weight range
// -----------------------------------------------------------------------------
package perceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    localparam int W_W_DEF   = 4;
    localparam int W_MAX_DEF = (32'sd1 <<< (W_W_DEF - 1)) - 32'sd1;
    localparam int W_MIN_DEF = -(32'sd1 <<< (W_W_DEF - 1));

    function automatic int w_max(input int w_w);
        return (32'sd1 <<< (w_w - 1)) - 32'sd1;
    endfunction

    function automatic int w_min(input int w_w);
        return -(32'sd1 <<< (w_w - 1));
    endfunction

    // Weights must never wrap: a wrapped weight flips sign and undoes learning.
    function automatic int sat_add(input int a, input int step, input int w_w);
        int s;
        s = a + step;
        if (s > w_max(w_w)) begin
            return w_max(w_w);
        end else if (s < w_min(w_w)) begin
            return w_min(w_w);
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/perceptron_if.sv
// -----------------------------------------------------------------------------
// perceptron_if
// Bundles the input-vector handshake, weight write port and classification
// outputs of the perceptron trainer.
//   master : drives in_valid, x_in, train, target, w_wr_en, w_wr_addr, w_wr_data
//            and observes in_ready, out_valid, y, sum, err_cnt
//   slave  : the mirror view used by perceptron_trainer
// -----------------------------------------------------------------------------
interface perceptron_if #(
    parameter int N_IN  = 4,
    parameter int W_W   = 4,
    parameter int CNT_W = 8
);
    localparam int AW    = $clog2(N_IN + 1);
    localparam int ACC_W = W_W + $clog2(N_IN + 1) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN-1:0]         x_in;
    logic                    train;
    logic                    target;
    logic                    w_wr_en;
    logic [AW-1:0]           w_wr_addr;
    logic signed [W_W-1:0]   w_wr_data;
    logic                    out_valid;
    logic                    y;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        err_cnt;

    modport master (
        output in_valid, x_in, train, target, w_wr_en, w_wr_addr, w_wr_data,
        input  in_ready, out_valid, y, sum, err_cnt
    );

    modport slave (
        input  in_valid, x_in, train, target, w_wr_en, w_wr_addr, w_wr_data,
        output in_ready, out_valid, y, sum, err_cnt
    );

endinterface

// File: rtl/perceptron_sat_add.sv
// -----------------------------------------------------------------------------
// perceptron_sat_add
// Combinational W_W-bit saturating add of +LR (inc_i=1) or -LR (inc_i=0).
//   a_i   : signed operand (a weight or the bias)
//   inc_i : direction of the learning step
//   sum_o : clamped result
// -----------------------------------------------------------------------------
module perceptron_sat_add
    import perceptron_pkg::*;
#(
    parameter int W_W = 4,
    parameter int LR  = 1
) (
    input  logic signed [W_W-1:0] a_i,
    input  logic                  inc_i,
    output logic signed [W_W-1:0] sum_o
);

    // Result always fits in W_W bits because sat_add clamps to the W_W range.
    assign sum_o = W_W'(sat_add(int'(a_i), inc_i ? LR : -LR, W_W));

endmodule

// File: rtl/perceptron_trainer.sv
// -----------------------------------------------------------------------------
// perceptron_trainer
// N_IN-input binary perceptron with register-based weights and online
// perceptron-rule learning. The bias is loaded into the accumulator, then one
// weight per cycle is added for each active input; the unit fires when the
// final sum is strictly positive. A misclassified training vector nudges the
// bias and every active weight toward the target in a single extra cycle.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; aborts any vector in flight
//   bus_if : slave view of perceptron_if (vector handshake, weight writes,
//            y/sum/out_valid result and saturating err_cnt)
// -----------------------------------------------------------------------------
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int W_W      = 4,
    parameter int LR       = 1,
    parameter int BIAS_RST = 3,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          reset,
    perceptron_if.slave   bus_if
);

    localparam int AW    = $clog2(N_IN + 1);
    localparam int IDX_W = $clog2(N_IN);
    localparam int ACC_W = W_W + $clog2(N_IN + 1) + 1;

    state_e                  state_q;
    logic signed [W_W-1:0]   w_q [N_IN];
    logic signed [W_W-1:0]   bias_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [IDX_W-1:0]        idx_q;
    logic [N_IN-1:0]         x_q;
    logic                    train_q;
    logic                    target_q;
    logic                    y_q;
    logic signed [ACC_W-1:0] sum_q;
    logic                    out_valid_q;
    logic [CNT_W-1:0]        err_cnt_q;

    logic signed [W_W-1:0]   w_upd_s [N_IN];
    logic signed [W_W-1:0]   bias_upd_s;
    logic signed [W_W-1:0]   w_sel_s;
    logic                    x_sel_s;
    logic signed [ACC_W-1:0] addend_s;
    logic                    acc_pos_s;
    logic                    in_ready_s;
    logic                    accept_s;

    // Candidate post-update values; only applied in UPDATE for active inputs.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_w_sat
        perceptron_sat_add #(.W_W(W_W), .LR(LR)) u_w_sat (
            .a_i   (w_q[gi]),
            .inc_i (target_q),
            .sum_o (w_upd_s[gi])
        );
    end

    perceptron_sat_add #(.W_W(W_W), .LR(LR)) u_bias_sat (
        .a_i   (bias_q),
        .inc_i (target_q),
        .sum_o (bias_upd_s)
    );

    // Select the weight and input bit for the current accumulation step.
    always_comb begin
        w_sel_s = {W_W{1'b0}};
        x_sel_s = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            w_sel_s = w_sel_s | ((idx_q == IDX_W'(i)) ? w_q[i] : {W_W{1'b0}});
            x_sel_s = x_sel_s | ((idx_q == IDX_W'(i)) ? x_q[i] : 1'b0);
        end
    end

    // Sign-extended addend, sign test of the accumulator and handshake.
    always_comb begin
        addend_s   = x_sel_s ? {{(ACC_W-W_W){w_sel_s[W_W-1]}}, w_sel_s} : {ACC_W{1'b0}};
        acc_pos_s  = !acc_q[ACC_W-1] && (acc_q != {ACC_W{1'b0}});
        // Weight writes win over vector acceptance in IDLE.
        in_ready_s = (state_q == ST_IDLE) && !bus_if.w_wr_en && !reset;
        accept_s   = in_ready_s && bus_if.in_valid;
    end

    // Controller, datapath and weight storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= {W_W{1'b0}};
            end
            bias_q      <= W_W'(BIAS_RST);
            acc_q       <= {ACC_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            x_q         <= {N_IN{1'b0}};
            train_q     <= 1'b0;
            target_q    <= 1'b0;
            y_q         <= 1'b0;
            sum_q       <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            err_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.w_wr_en) begin
                        if (bus_if.w_wr_addr == AW'(N_IN)) begin
                            bias_q <= bus_if.w_wr_data;
                        end else begin
                            for (int i = 0; i < N_IN; i++) begin
                                if (bus_if.w_wr_addr == AW'(i)) begin
                                    w_q[i] <= bus_if.w_wr_data;
                                end
                            end
                        end
                    end else if (accept_s) begin
                        x_q      <= bus_if.x_in;
                        train_q  <= bus_if.train;
                        target_q <= bus_if.target;
                        acc_q    <= {{(ACC_W-W_W){bias_q[W_W-1]}}, bias_q};
                        idx_q    <= {IDX_W{1'b0}};
                        state_q  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_q + addend_s;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_IN - 1)) begin
                        state_q <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    y_q         <= acc_pos_s;
                    sum_q       <= acc_q;
                    out_valid_q <= 1'b1;
                    if (train_q && (acc_pos_s != target_q)) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (x_q[i]) begin
                            w_q[i] <= w_upd_s[i];
                        end
                    end
                    bias_q <= bias_upd_s;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.in_ready  = in_ready_s;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.y         = y_q;
    assign bus_if.sum       = sum_q;
    assign bus_if.err_cnt   = err_cnt_q;

endmodule
